muldiv_sched: RTL

- Controller sitting between the execute stage and the multi-cycle mult/div engines.
- Accepts one HI/LO arithmetic request (MULT, MULTU, DIV, DIVU) at a time.
- Converts signed operands to magnitudes, starts the right engine, and holds it with a level valid until done.
- Applies sign fix-up, raises the pipeline stall, and holds the {hi,lo} result until the pipeline advances; flushes abort in-flight work.

---
 rtl/muldiv_sched_pkg.sv | 26 ++
 rtl/muldiv_sched_if.sv | 42 ++++
 rtl/muldiv_signfix.sv | 30 +++
 rtl/muldiv_sched.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared types and constants for the HI/LO mult/div scheduler.
// Optional zero-operand bypass in the top is enabled by MULDIV_ZERO_BYPASS_EN.
package muldiv_sched_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      StIdle,
      StBusyMul,
      StBusyDiv,
      StDone
   } muldiv_state_t;

   localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

   // Two's-complement negate when neg is set, pass-through otherwise.
   function automatic logic [31:0] md_mag(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// Pipeline and engine signals of the mult/div scheduler.
// slave is the scheduler's view; master is the surrounding pipeline and engines.
interface muldiv_sched_if;
   import muldiv_sched_pkg::*;

   logic          req_valid;
   muldiv_op_t    req_op;
   logic [31:0]   req_a;
   logic [31:0]   req_b;
   logic          advance;
   logic          flush;
   logic          stall;
   logic          res_valid;
   logic [31:0]   res_hi;
   logic [31:0]   res_lo;
   logic          res_err;
   logic          mul_valid;
   logic [31:0]   mul_a;
   logic [31:0]   mul_b;
   logic          mul_done;
   logic [63:0]   mul_c;
   logic          div_valid;
   logic [31:0]   div_a;
   logic [31:0]   div_b;
   logic          div_done;
   logic [63:0]   div_c;

   modport slave (
      input  req_valid, req_op, req_a, req_b, advance, flush,
      input  mul_done, mul_c, div_done, div_c,
      output stall, res_valid, res_hi, res_lo, res_err,
      output mul_valid, mul_a, mul_b, div_valid, div_a, div_b
   );

   modport master (
      output req_valid, req_op, req_a, req_b, advance, flush,
      output mul_done, mul_c, div_done, div_c,
      input  stall, res_valid, res_hi, res_lo, res_err,
      input  mul_valid, mul_a, mul_b, div_valid, div_a, div_b
   );

endinterface

// File: rtl/muldiv_signfix.sv
// Maps an unsigned engine result back to the signed {hi,lo} of the original op.
// Divider results arrive as {remainder, quotient}.
module muldiv_signfix
   import muldiv_sched_pkg::*;
(
   input  muldiv_op_t  op,
   input  logic        sign_a,
   input  logic        sign_b,
   input  logic [63:0] raw,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   always_comb begin
      hi = raw[63:32];
      lo = raw[31:0];
      case (op)
         MD_MULT: begin
            {hi, lo} = (sign_a ^ sign_b) ? (~raw + 64'd1) : raw;
         end
         MD_DIV: begin
            // Quotient takes the product sign, remainder follows the dividend.
            lo = md_mag(raw[31:0], sign_a ^ sign_b);
            hi = md_mag(raw[63:32], sign_a);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/muldiv_sched.sv
// Scheduler between execute and the multi-cycle mult/div engines.
// Define MULDIV_ZERO_BYPASS_EN to skip the engines for zero operands.
module muldiv_sched
   import muldiv_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_sched_if.slave bus
);

   muldiv_state_t state_q, state_d;
   muldiv_op_t    op_q, op_d;
   logic          sign_a_q, sign_a_d;
   logic          sign_b_q, sign_b_d;
   logic [31:0]   mag_a_q, mag_a_d;
   logic [31:0]   mag_b_q, mag_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          err_q, err_d;

   logic          req_signed, req_is_div, req_sa, req_sb;
   logic          eng_done, stall;
   logic [63:0]   eng_raw;
   logic [31:0]   fix_hi, fix_lo;

   assign req_signed = (bus.req_op == MD_MULT) || (bus.req_op == MD_DIV);
   assign req_is_div = (bus.req_op == MD_DIV) || (bus.req_op == MD_DIVU);
   assign req_sa     = req_signed & bus.req_a[31];
   assign req_sb     = req_signed & bus.req_b[31];
   assign eng_raw    = (state_q == StBusyDiv) ? bus.div_c : bus.mul_c;

`ifdef MULDIV_ZERO_BYPASS_EN
   logic zero_bypass;
   assign zero_bypass = req_is_div ? (bus.req_a == '0)
                                   : ((bus.req_a == '0) || (bus.req_b == '0));
`endif

   muldiv_signfix u_signfix (
      .op     (op_q),
      .sign_a (sign_a_q),
      .sign_b (sign_b_q),
      .raw    (eng_raw),
      .hi     (fix_hi),
      .lo     (fix_lo)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      mag_a_d  = mag_a_q;
      mag_b_d  = mag_b_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      err_d    = err_q;
      eng_done = 1'b0;
      stall    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid && !bus.flush) begin
               stall    = 1'b1;
               op_d     = bus.req_op;
               sign_a_d = req_sa;
               sign_b_d = req_sb;
               mag_a_d  = md_mag(bus.req_a, req_sa);
               mag_b_d  = md_mag(bus.req_b, req_sb);
               cnt_d    = '0;
               err_d    = 1'b0;
               if (req_is_div && (bus.req_b == '0)) begin
                  state_d = StDone;
                  hi_d    = bus.req_a;
                  lo_d    = MD_DIV0_LO;
               end
`ifdef MULDIV_ZERO_BYPASS_EN
               else if (zero_bypass) begin
                  state_d = StDone;
                  hi_d    = '0;
                  lo_d    = '0;
               end
`endif
               else if (req_is_div) begin
                  state_d = StBusyDiv;
               end else begin
                  state_d = StBusyMul;
               end
            end
         end
         StBusyMul, StBusyDiv: begin
            stall    = 1'b1;
            eng_done = (state_q == StBusyMul) ? bus.mul_done : bus.div_done;
            cnt_d    = cnt_q + CNT_W'(1);
            if (eng_done) begin
               state_d = StDone;
               hi_d    = fix_hi;
               lo_d    = fix_lo;
               err_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = StDone;
               hi_d    = '0;
               lo_d    = '0;
               err_d   = 1'b1;
            end
         end
         StDone: begin
            if (bus.advance) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Flush beats done/advance; the held result is left untouched.
      if (bus.flush) begin
         state_d = StIdle;
         cnt_d   = '0;
         err_d   = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         op_q     <= MD_MULT;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         mag_a_q  <= mag_a_d;
         mag_b_q  <= mag_b_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         err_q    <= err_d;
      end
   end

   assign bus.stall     = stall;
   assign bus.res_valid = (state_q == StDone);
   assign bus.res_hi    = hi_q;
   assign bus.res_lo    = lo_q;
   assign bus.res_err   = err_q && (state_q == StDone);
   assign bus.mul_valid = (state_q == StBusyMul);
   assign bus.mul_a     = mag_a_q;
   assign bus.mul_b     = mag_b_q;
   assign bus.div_valid = (state_q == StBusyDiv);
   assign bus.div_a     = mag_a_q;
   assign bus.div_b     = mag_b_q;

endmodule
